// File: rtl/fifo_ram_pkg.sv
// Shared helpers for the outbound FIFO storage RAM: byte-parity generation and
// derived-parameter functions used by the RAM top and its array.
package fifo_ram_pkg;

  // Widest data path the parity helper supports. Callers zero-extend into it.
  localparam int MAX_WIDTH  = 1024;
  localparam int MAX_NBYTES = MAX_WIDTH / 8;

  // Even parity per byte: bit i is the XOR of data byte i.
  function automatic logic [MAX_NBYTES-1:0] byte_parity(input logic [MAX_WIDTH-1:0] data);
    logic [MAX_NBYTES-1:0] par;
    par = '0;
    for (int i = 0; i < MAX_NBYTES; i++) begin
      par[i] = ^data[i*8 +: 8];
    end
    return par;
  endfunction

  function automatic int nbytes(input int width);
    return width / 8;
  endfunction

  function automatic int rd_lat(input int pipe);
    return 1 + pipe;
  endfunction

endpackage

// File: rtl/fifo_ram_array.sv
// Plain simple-dual-port storage array with registered read and no reset, so
// synthesis can map it straight onto LSRAM.
module fifo_ram_array #(
  parameter int DW     = 36,
  parameter int DEPTH  = 128,
  parameter int AWIDTH = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AWIDTH-1:0] waddr_i,
  input  logic [DW-1:0]     wdata_i,
  input  logic              re_i,
  input  logic [AWIDTH-1:0] raddr_i,
  output logic [DW-1:0]     rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // NOTE: neither the array nor its read register is reset; a reset would stop them mapping onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/outbound_fifo_ram_pipe.sv
// Outbound FIFO storage RAM: write-first bypass, per-byte parity check,
// out-of-range address flagging and a 1- or 2-cycle read pipeline with RVALID.
module outbound_fifo_ram_pipe
  import fifo_ram_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 128,
  parameter int AWIDTH = $clog2(DEPTH),
  parameter int PIPE   = 1,
  parameter int PARITY = 1
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic [WIDTH-1:0]  WDATA,
  input  logic [AWIDTH-1:0] WADDR,
  input  logic              WEN,
  input  logic              ERR_INJ,
  input  logic [AWIDTH-1:0] RADDR,
  input  logic              REN,
  output logic [WIDTH-1:0]  RDATA,
  output logic              RVALID,
  output logic              PAR_ERR,
  output logic              ADDR_ERR
);

  localparam int NBYTES = nbytes(WIDTH);
  // With parity disabled a single constant-zero bit keeps the word layout uniform.
  localparam int PBITS  = (PARITY != 0) ? NBYTES : 1;
  localparam int RD_LAT = rd_lat(PIPE);
  localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH+1)'(DEPTH);

  logic [MAX_NBYTES-1:0]  wpar_all, rpar_all;
  logic [PBITS-1:0]       wpar, s1_par;
  logic [WIDTH+PBITS-1:0] mem_word, byp_word_q, s1_word;
  logic [WIDTH-1:0]       s1_data;
  logic                   wen_ok, raddr_bad, byp;
  logic                   s1_valid_q, s1_byp_q, s1_aerr_q, s1_perr;
  logic                   unused_par;

  assign wen_ok    = WEN && ({1'b0, WADDR} < DEPTH_W);
  assign raddr_bad = ({1'b0, RADDR} >= DEPTH_W);
  assign byp       = wen_ok && (WADDR == RADDR);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    wpar_all = byte_parity(MAX_WIDTH'(WDATA));
    wpar     = '0;
    if (PARITY != 0) wpar = wpar_all[PBITS-1:0] ^ PBITS'(ERR_INJ);
  end

  fifo_ram_array #(.DW(WIDTH + PBITS), .DEPTH(DEPTH), .AWIDTH(AWIDTH)) u_array (
    .clk_i   (CLOCK),
    .we_i    (wen_ok),
    .waddr_i (WADDR),
    .wdata_i ({wpar, WDATA}),
    .re_i    (REN && !raddr_bad),
    .raddr_i (RADDR),
    .rdata_o (mem_word)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_valid_q <= 1'b0;
      s1_byp_q   <= 1'b0;
      s1_aerr_q  <= 1'b0;
      byp_word_q <= '0;
    end else begin
      s1_valid_q <= REN;
      if (REN) begin
        s1_byp_q   <= byp;
        s1_aerr_q  <= raddr_bad;
        byp_word_q <= {wpar, WDATA};
      end
    end
  end

  always_comb begin
    s1_word = mem_word;
    if (s1_byp_q)  s1_word = byp_word_q;
    if (s1_aerr_q) s1_word = '0;
    s1_data  = s1_word[WIDTH-1:0];
    s1_par   = s1_word[WIDTH +: PBITS];
    rpar_all = byte_parity(MAX_WIDTH'(s1_data));
    s1_perr  = 1'b0;
    if (PARITY != 0) s1_perr = s1_valid_q && (rpar_all[PBITS-1:0] != s1_par);
  end

  assign unused_par = ^{wpar_all, rpar_all, s1_par};

  if (RD_LAT == 1) begin : g_lat1
    logic has_data_q;

    // The array read register has no reset, so RDATA stays 0 until a read lands.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N)  has_data_q <= 1'b0;
      else if (REN)  has_data_q <= 1'b1;
    end

    assign RDATA    = has_data_q ? s1_data : '0;
    assign RVALID   = s1_valid_q;
    assign PAR_ERR  = s1_perr;
    assign ADDR_ERR = s1_valid_q && s1_aerr_q;
  end else begin : g_lat2
    logic [WIDTH-1:0] rdata_q;
    logic             rvalid_q, perr_q, aerr_q;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
        perr_q   <= 1'b0;
        aerr_q   <= 1'b0;
      end else begin
        rvalid_q <= s1_valid_q;
        perr_q   <= s1_perr;
        aerr_q   <= s1_valid_q && s1_aerr_q;
        if (s1_valid_q) rdata_q <= s1_data;
      end
    end

    assign RDATA    = rdata_q;
    assign RVALID   = rvalid_q;
    assign PAR_ERR  = perr_q;
    assign ADDR_ERR = aerr_q;
  end

endmodule

// File: tb/tb_outbound_fifo_ram_pipe.sv
// Directed bench for outbound_fifo_ram_pipe: a latency-2 instance (DEPTH=128) and
// a latency-1 instance (DEPTH=100) share one stimulus stream.
module tb_outbound_fifo_ram_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] wdata;
  logic [6:0]  waddr, raddr;
  logic        wen, err_inj, ren;

  logic [31:0] rdata0, rdata1;
  logic        rvalid0, rvalid1, perr0, perr1, aerr0, aerr1;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  outbound_fifo_ram_pipe #(.WIDTH(32), .DEPTH(100), .PIPE(0), .PARITY(1)) dut_p0 (
    .CLOCK(clk), .RESET_N(rst_n), .WDATA(wdata), .WADDR(waddr), .WEN(wen),
    .ERR_INJ(err_inj), .RADDR(raddr), .REN(ren), .RDATA(rdata0), .RVALID(rvalid0),
    .PAR_ERR(perr0), .ADDR_ERR(aerr0)
  );

  outbound_fifo_ram_pipe #(.WIDTH(32), .DEPTH(128), .PIPE(1), .PARITY(1)) dut_p1 (
    .CLOCK(clk), .RESET_N(rst_n), .WDATA(wdata), .WADDR(waddr), .WEN(wen),
    .ERR_INJ(err_inj), .RADDR(raddr), .REN(ren), .RDATA(rdata1), .RVALID(rvalid1),
    .PAR_ERR(perr1), .ADDR_ERR(aerr1)
  );

  // Packed observation: {RVALID, PAR_ERR, ADDR_ERR, RDATA}.
  typedef struct {
    logic        wen;
    logic [6:0]  waddr;
    logic [31:0] wdata;
    logic        err;
    logic        ren;
    logic [6:0]  raddr;
    logic [34:0] exp0;
    logic [34:0] exp1;
  } vec_t;

  vec_t tbl[17];

  function automatic logic [34:0] o(input int v, input int pe, input int ae, input logic [31:0] d);
    return {v[0], pe[0], ae[0], d};
  endfunction

  function automatic vec_t mk(input int we, input int wa, input logic [31:0] wd, input int ei,
                              input int re, input int ra, input logic [34:0] e0, input logic [34:0] e1);
    vec_t v;
    v.wen = we[0]; v.waddr = wa[6:0]; v.wdata = wd; v.err = ei[0];
    v.ren = re[0]; v.raddr = ra[6:0]; v.exp0 = e0; v.exp1 = e1;
    return v;
  endfunction

  function automatic logic [31:0] bword(input int i);
    return 32'hA5A5_0000 + 32'(i * 17);
  endfunction

  task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got v/pe/ae/data=%b/%b/%b/%h, want %b/%b/%b/%h", name,
               act[34], act[33], act[32], act[31:0], exp[34], exp[33], exp[32], exp[31:0]);
    end
  endtask

  task automatic check_both(input string name, input logic [34:0] e0, input logic [34:0] e1);
    check({name, "/lat1"}, {rvalid0, perr0, aerr0, rdata0}, e0);
    check({name, "/lat2"}, {rvalid1, perr1, aerr1, rdata1}, e1);
  endtask

  task automatic drive(input logic we, input int wa, input logic [31:0] wd, input logic ei,
                       input logic re, input int ra);
    wen = we; waddr = wa[6:0]; wdata = wd; err_inj = ei; ren = re; raddr = ra[6:0];
  endtask

  // Advance one clock and settle just past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 0, 32'h0, 1'b0, 1'b0, 0);
    step();
    step();
    check_both("reset", o(0, 0, 0, 0), o(0, 0, 0, 0));
    rst_n = 1'b1;

    tbl[0]  = mk(1, 5,   32'hDEADBEEF, 0, 0, 0,   o(0,0,0,0),            o(0,0,0,0));
    tbl[1]  = mk(0, 0,   32'h0,        0, 1, 5,   o(1,0,0,32'hDEADBEEF), o(0,0,0,0));
    tbl[2]  = mk(0, 0,   32'h0,        0, 0, 0,   o(0,0,0,32'hDEADBEEF), o(1,0,0,32'hDEADBEEF));
    tbl[3]  = mk(1, 9,   32'h12345678, 0, 1, 9,   o(1,0,0,32'h12345678), o(0,0,0,32'hDEADBEEF));
    tbl[4]  = mk(1, 3,   32'h000000FF, 1, 0, 0,   o(0,0,0,32'h12345678), o(1,0,0,32'h12345678));
    tbl[5]  = mk(0, 0,   32'h0,        0, 1, 3,   o(1,1,0,32'h000000FF), o(0,0,0,32'h12345678));
    tbl[6]  = mk(1, 3,   32'h000000FF, 0, 0, 0,   o(0,0,0,32'h000000FF), o(1,1,0,32'h000000FF));
    tbl[7]  = mk(0, 0,   32'h0,        0, 1, 3,   o(1,0,0,32'h000000FF), o(0,0,0,32'h000000FF));
    tbl[8]  = mk(1, 99,  32'hCAFEF00D, 0, 0, 0,   o(0,0,0,32'h000000FF), o(1,0,0,32'h000000FF));
    tbl[9]  = mk(1, 120, 32'hBADC0DE5, 0, 0, 0,   o(0,0,0,32'h000000FF), o(0,0,0,32'h000000FF));
    tbl[10] = mk(0, 0,   32'h0,        0, 1, 120, o(1,0,1,32'h0),        o(0,0,0,32'h000000FF));
    tbl[11] = mk(0, 0,   32'h0,        0, 1, 99,  o(1,0,0,32'hCAFEF00D), o(1,0,0,32'hBADC0DE5));
    tbl[12] = mk(0, 0,   32'h0,        0, 0, 0,   o(0,0,0,32'hCAFEF00D), o(1,0,0,32'hCAFEF00D));
    tbl[13] = mk(1, 9,   32'h0,        1, 1, 9,   o(1,1,0,32'h0),        o(0,0,0,32'hCAFEF00D));
    tbl[14] = mk(0, 0,   32'h0,        0, 0, 0,   o(0,0,0,32'h0),        o(1,1,0,32'h0));
    tbl[15] = mk(1, 120, 32'h11111111, 0, 1, 120, o(1,0,1,32'h0),        o(0,0,0,32'h0));
    tbl[16] = mk(0, 0,   32'h0,        0, 0, 0,   o(0,0,0,32'h0),        o(1,0,0,32'h11111111));

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].wen, int'(tbl[i].waddr), tbl[i].wdata, tbl[i].err, tbl[i].ren, int'(tbl[i].raddr));
      step();
      check_both($sformatf("vec%0d", i), tbl[i].exp0, tbl[i].exp1);
    end

    // Fill words 0..7, then read them back-to-back and let the pipes drain.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i, bword(i), 1'b0, 1'b0, 0);
      step();
    end
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 0, 32'h0, 1'b0, k < 8, (k < 8) ? k : 0);
      step();
      check_both($sformatf("burst%0d", k),
                 (k < 8) ? o(1, 0, 0, bword(k)) : o(0, 0, 0, bword(7)),
                 (k == 0) ? o(0, 0, 0, 32'h11111111) :
                 (k <= 8) ? o(1, 0, 0, bword(k - 1)) : o(0, 0, 0, bword(7)));
    end

    // Reset lands in the middle of a burst; outputs must clear without a clock edge.
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 0, 32'h0, 1'b0, 1'b1, k);
      step();
    end
    rst_n = 1'b0;
    drive(1'b0, 0, 32'h0, 1'b0, 1'b0, 0);
    #1;
    check_both("rst_async", o(0, 0, 0, 0), o(0, 0, 0, 0));
    step();
    check_both("rst_held", o(0, 0, 0, 0), o(0, 0, 0, 0));
    rst_n = 1'b1;

    drive(1'b0, 0, 32'h0, 1'b0, 1'b1, 2);
    step();
    check_both("post_rst_a", o(1, 0, 0, bword(2)), o(0, 0, 0, 0));
    drive(1'b0, 0, 32'h0, 1'b0, 1'b1, 6);
    step();
    check_both("post_rst_b", o(1, 0, 0, bword(6)), o(1, 0, 0, bword(2)));
    drive(1'b0, 0, 32'h0, 1'b0, 1'b1, 99);
    step();
    check_both("post_rst_c", o(1, 0, 0, 32'hCAFEF00D), o(1, 0, 0, bword(6)));
    drive(1'b0, 0, 32'h0, 1'b0, 1'b0, 0);
    step();
    check_both("post_rst_d", o(0, 0, 0, 32'hCAFEF00D), o(1, 0, 0, 32'hCAFEF00D));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
